// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. It owns the PC and issues one word read at a time
// on the memory fetch port. Returned instructions go into a small FIFO that
// feeds decode. Redirects from execute flush the stage and restart fetch.
//
// Ports:
//   clk            clock
//   reset_n        synchronous active-low reset
//   fe_req         fetch request to memory (combinational, credit-gated)
//   fe_addr        fetch address (always word aligned, equals the PC)
//   fe_ack         memory accepted the request this cycle
//   fe_data        read data, valid the cycle after an acked request
//   redirect_valid execute redirect (branch/jump/trap)
//   redirect_pc    redirect target; a misaligned target raises a fetch fault
//   de_valid       instruction buffer head is valid
//   de_ready       decode consumes the head this cycle
//   de_pc          PC of the head instruction
//   de_insn        head instruction word
//   de_misaligned  head carries a misaligned-fetch fault
//   de_pred_taken  head JAL was predicted taken
//
// Build option:
//   FETCH_PREDICT_EN  when defined, a JAL whose target is word aligned is
//                     followed at fetch time and its entry is marked
//                     de_pred_taken. When undefined, de_pred_taken is 0.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        fe_req,
    output logic [31:0] fe_addr,
    input  logic        fe_ack,
    input  logic [31:0] fe_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        de_valid,
    input  logic        de_ready,
    output logic [31:0] de_pc,
    output logic [31:0] de_insn,
    output logic        de_misaligned,
    output logic        de_pred_taken
);

    localparam int          PW       = $clog2(QDEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FAULT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;

    logic [31:0]    pc_r;
    logic [31:0]    resp_pc_r;
    logic [31:0]    fault_pc_r;
    logic           inflight_r;
    logic           kill_r;

    logic [31:0]    q_pc_r   [QDEPTH];
    logic [31:0]    q_insn_r [QDEPTH];
    logic           q_mis_r  [QDEPTH];
    logic           q_pred_r [QDEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;

    logic           pop_s;
    logic [CW:0]    need_s;
    logic           fe_req_s;
    logic           ack_s;
    logic           resp_s;
    logic           fault_push_s;
    logic           pred_take_s;
    logic [31:0]    pred_target_s;

    logic           push_s;
    logic [31:0]    push_pc_s;
    logic [31:0]    push_insn_s;
    logic           push_mis_s;
    logic           push_pred_s;

    assign de_valid = (count_r != {CW{1'b0}});
    assign pop_s    = de_valid & de_ready;

    // Slots that would be occupied after this cycle's pop, counting the
    // response already in flight; a new request needs one free slot.
    assign need_s   = {1'b0, count_r} + (CW + 1)'(inflight_r) - (CW + 1)'(pop_s);
    assign fe_req_s = reset_n & (state_r == ST_RUN) & ~redirect_valid
                    & (need_s < (CW + 1)'(QDEPTH));
    assign ack_s    = fe_req_s & fe_ack;

    assign fe_req   = fe_req_s;
    assign fe_addr  = pc_r;

    // A response is dropped when a prediction killed it or a redirect
    // flushes the stage in the cycle it arrives.
    assign resp_s       = inflight_r & ~kill_r & ~redirect_valid;
    assign fault_push_s = (state_r == ST_FAULT) & ~redirect_valid;

`ifdef FETCH_PREDICT_EN
    function automatic logic [31:0] jal_target(input logic [31:0] pc,
                                               input logic [31:0] insn);
        return pc + {{11{insn[31]}}, insn[31], insn[19:12], insn[20],
                     insn[30:21], 1'b0};
    endfunction

    assign pred_target_s = jal_target(resp_pc_r, fe_data);
    // Only word-aligned JAL targets are followed; the rest fall through.
    assign pred_take_s   = resp_s & (fe_data[6:0] == 7'b1101111)
                         & ~pred_target_s[1];
`else
    assign pred_target_s = 32'h0000_0000;
    assign pred_take_s   = 1'b0;
`endif

    // Select what enters the buffer: the fault marker or a memory response.
    always_comb begin
        push_s      = 1'b0;
        push_pc_s   = 32'h0000_0000;
        push_insn_s = 32'h0000_0000;
        push_mis_s  = 1'b0;
        push_pred_s = 1'b0;
        if (fault_push_s) begin
            push_s      = 1'b1;
            push_pc_s   = fault_pc_r;
            push_insn_s = NOP_INSN;
            push_mis_s  = 1'b1;
        end else if (resp_s) begin
            push_s      = 1'b1;
            push_pc_s   = resp_pc_r;
            push_insn_s = fe_data;
            push_pred_s = pred_take_s;
        end else begin
            push_s      = 1'b0;
        end
    end

    // Next-state logic: a redirect re-evaluates from any state.
    always_comb begin
        state_next_s = state_r;
        if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
                state_next_s = ST_FAULT;
            end else begin
                state_next_s = ST_RUN;
            end
        end else begin
            case (state_r)
                ST_RUN:   state_next_s = ST_RUN;
                ST_FAULT: state_next_s = ST_HALT;
                ST_HALT:  state_next_s = ST_HALT;
                default:  state_next_s = ST_HALT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC update: redirect beats prediction, prediction beats sequential.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= {redirect_pc[31:2], 2'b00};
        end else if (pred_take_s) begin
            pc_r <= pred_target_s;
        end else if (ack_s) begin
            pc_r <= pc_r + 32'd4;
        end
    end

    // In-flight request tracking and fault address capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inflight_r <= 1'b0;
            kill_r     <= 1'b0;
            resp_pc_r  <= 32'h0000_0000;
            fault_pc_r <= 32'h0000_0000;
        end else begin
            inflight_r <= ack_s;
            // The fall-through fetch issued alongside a taken prediction
            // must not reach the buffer.
            kill_r     <= ack_s & pred_take_s;
            if (ack_s) begin
                resp_pc_r <= pc_r;
            end
            if (redirect_valid) begin
                fault_pc_r <= redirect_pc;
            end
        end
    end

    // Instruction buffer storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc_r[i]   <= 32'h0000_0000;
                q_insn_r[i] <= 32'h0000_0000;
                q_mis_r[i]  <= 1'b0;
                q_pred_r[i] <= 1'b0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (redirect_valid) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                q_pc_r[wr_ptr_r]   <= push_pc_s;
                q_insn_r[wr_ptr_r] <= push_insn_s;
                q_mis_r[wr_ptr_r]  <= push_mis_s;
                q_pred_r[wr_ptr_r] <= push_pred_s;
                wr_ptr_r           <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    assign de_pc         = q_pc_r[rd_ptr_r];
    assign de_insn       = q_insn_r[rd_ptr_r];
    assign de_misaligned = q_mis_r[rd_ptr_r];
    assign de_pred_taken = q_pred_r[rd_ptr_r];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage: a cycle-by-cycle vector table for the
// directed scenarios, a hand-written JAL sequence, and a randomized run whose
// consumed entries are compared with a program-order stream model.
// Honors FETCH_PREDICT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

`ifdef FETCH_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fe_req;
    logic [31:0] fe_addr;
    logic        fe_ack;
    logic [31:0] fe_data = 32'h0000_0000;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        de_valid;
    logic        de_ready;
    logic [31:0] de_pc;
    logic [31:0] de_insn;
    logic        de_misaligned;
    logic        de_pred_taken;

    int checks = 0;
    int errors = 0;
    bit jal_on   = 1'b0;
    bit rand_jal = 1'b0;

    fetch_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fe_req         (fe_req),
        .fe_addr        (fe_addr),
        .fe_ack         (fe_ack),
        .fe_data        (fe_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .de_valid       (de_valid),
        .de_ready       (de_ready),
        .de_pc          (de_pc),
        .de_insn        (de_insn),
        .de_misaligned  (de_misaligned),
        .de_pred_taken  (de_pred_taken)
    );

    always #5 clk = ~clk;

    // Memory image: fixed words at 0 and 0x10, hashed JALs in the random run.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        if (a == 32'h0000_0000) return 32'h0050_0093;
        if (jal_on && a == 32'h0000_0010) return 32'h0200_006f;
        if (rand_jal && h[27:25] == 3'b000) return {h[31:12], 5'd1, 7'b1101111};
        return {a[23:0], 8'h13};
    endfunction

    // Memory fetch port: data returned the cycle after an accepted request.
    always @(posedge clk) begin
        if (fe_req && fe_ack) fe_data <= mem_word(fe_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst_n;
        logic        ack;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        int          dv;    // 0/1 expected de_valid, 2 = not checked
        logic [31:0] pc;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic ack, input logic rdy,
                       input logic rv, input logic [31:0] rpc, input logic req,
                       input logic [31:0] addr, input int dv,
                       input logic [31:0] pc, input logic mis);
        vec_t v;
        v.rst_n = rst_n; v.ack = ack; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.req = req; v.addr = addr; v.dv = dv; v.pc = pc; v.mis = mis;
        vecs.push_back(v);
    endtask

    task automatic add_reset();
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2, 32'h0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        reset_n = 1'b0; fe_ack = 1'b0; de_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // ---------------- stream reference model ----------------
    logic [31:0] m_pc;
    int          m_mode;      // 0 fetching, 1 fault entry pending, 2 halted
    logic [31:0] m_fault_pc;

    function automatic logic [31:0] jal_offset(input logic [31:0] insn);
        int imm;
        imm = int'(insn[30:21]) * 2 + int'(insn[20]) * 2048
            + int'(insn[19:12]) * 4096 - (insn[31] ? 1048576 : 0);
        return 32'(imm);
    endfunction

    task automatic model_next(output bit ok, output logic [31:0] pc,
                              output logic [31:0] insn, output logic mis,
                              output logic pred);
        logic [31:0] tgt;
        ok = 1'b1; pc = 32'h0; insn = 32'h0; mis = 1'b0; pred = 1'b0;
        if (m_mode == 0) begin
            pc   = m_pc;
            insn = mem_word(m_pc);
            tgt  = m_pc + jal_offset(insn);
            if (PRED && insn[6:0] == 7'b1101111 && tgt[1] == 1'b0) begin
                pred = 1'b1;
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else if (m_mode == 1) begin
            pc = m_fault_pc; insn = 32'h0000_0013; mis = 1'b1;
            m_mode = 2;
        end else begin
            ok = 1'b0;
        end
    endtask

    task automatic model_redirect(input logic [31:0] rpc);
        if (rpc[1:0] != 2'b00) begin
            m_mode = 1; m_fault_pc = rpc;
        end else begin
            m_mode = 0; m_pc = rpc;
        end
    endtask

    initial begin
        reset_n = 1'b0; fe_ack = 1'b0; de_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Test 1: streaming from reset
        add(1,1,1,0,32'h0, 1,32'h00, 0,32'h0,0);
        add(1,1,1,0,32'h0, 1,32'h04, 0,32'h0,0);
        add(1,1,1,0,32'h0, 1,32'h08, 1,32'h0,0);
        add(1,1,1,0,32'h0, 1,32'h0C, 1,32'h4,0);
        add(1,1,1,0,32'h0, 1,32'h10, 1,32'h8,0);
        add_reset();
        // Test 2: ack withheld three cycles at 0x8
        add(1,1,1,0,32'h0, 1,32'h00, 0,32'h0,0);
        add(1,1,1,0,32'h0, 1,32'h04, 0,32'h0,0);
        add(1,0,1,0,32'h0, 1,32'h08, 1,32'h0,0);
        add(1,0,1,0,32'h0, 1,32'h08, 1,32'h4,0);
        add(1,0,1,0,32'h0, 1,32'h08, 0,32'h0,0);
        add(1,1,1,0,32'h0, 1,32'h08, 0,32'h0,0);
        add(1,1,1,0,32'h0, 1,32'h0C, 0,32'h0,0);
        add(1,1,1,0,32'h0, 1,32'h10, 1,32'h8,0);
        add(1,1,1,0,32'h0, 1,32'h14, 1,32'hC,0);
        add_reset();
        // Test 3: decode stalls five cycles
        add(1,1,0,0,32'h0, 1,32'h00, 0,32'h0,0);
        add(1,1,0,0,32'h0, 1,32'h04, 0,32'h0,0);
        add(1,1,0,0,32'h0, 0,32'h00, 1,32'h0,0);
        add(1,1,0,0,32'h0, 0,32'h00, 1,32'h0,0);
        add(1,1,0,0,32'h0, 0,32'h00, 1,32'h0,0);
        add(1,1,1,0,32'h0, 1,32'h08, 1,32'h0,0);
        add(1,1,1,0,32'h0, 1,32'h0C, 1,32'h4,0);
        add(1,1,1,0,32'h0, 1,32'h10, 1,32'h8,0);
        add_reset();
        // Test 4: redirect with an entry buffered and a response in flight
        add(1,1,0,0,32'h0,   1,32'h000, 0,32'h0,0);
        add(1,1,0,0,32'h0,   1,32'h004, 0,32'h0,0);
        add(1,1,0,1,32'h100, 0,32'h000, 1,32'h0,0);
        add(1,1,1,0,32'h0,   1,32'h100, 0,32'h0,0);
        add(1,1,1,0,32'h0,   1,32'h104, 0,32'h0,0);
        add(1,1,1,0,32'h0,   1,32'h108, 1,32'h100,0);
        add(1,1,1,0,32'h0,   1,32'h10C, 1,32'h104,0);
        // Test 5: misaligned redirect, halt, then recovery at 0x200
        add(1,1,1,1,32'h102, 0,32'h000, 1,32'h108,0);
        add(1,1,0,0,32'h0,   0,32'h000, 0,32'h0,0);
        add(1,1,0,0,32'h0,   0,32'h000, 1,32'h102,1);
        add(1,1,1,0,32'h0,   0,32'h000, 1,32'h102,1);
        add(1,1,1,0,32'h0,   0,32'h000, 0,32'h0,0);
        add(1,1,1,1,32'h200, 0,32'h000, 0,32'h0,0);
        add(1,1,1,0,32'h0,   1,32'h200, 0,32'h0,0);
        add(1,1,1,0,32'h0,   1,32'h204, 0,32'h0,0);
        add(1,1,1,0,32'h0,   1,32'h208, 1,32'h200,0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fe_req", 32'(fe_req), 32'h0);
        check("rst_de_valid", 32'(de_valid), 32'h0);
        check("rst_de_pc", de_pc, 32'h0);
        check("rst_de_insn", de_insn, 32'h0);
        check("rst_de_misaligned", 32'(de_misaligned), 32'h0);
        check("rst_de_pred_taken", 32'(de_pred_taken), 32'h0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            reset_n = vecs[i].rst_n; fe_ack = vecs[i].ack; de_ready = vecs[i].rdy;
            redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
            @(negedge clk);
            check($sformatf("v%0d_fe_req", i), 32'(fe_req), 32'(vecs[i].req));
            if (vecs[i].req) check($sformatf("v%0d_fe_addr", i), fe_addr, vecs[i].addr);
            if (vecs[i].dv != 2) check($sformatf("v%0d_de_valid", i), 32'(de_valid), 32'(vecs[i].dv));
            if (vecs[i].dv == 1) begin
                check($sformatf("v%0d_de_pc", i), de_pc, vecs[i].pc);
                check($sformatf("v%0d_de_insn", i), de_insn,
                      vecs[i].mis ? 32'h0000_0013 : mem_word(vecs[i].pc));
                check($sformatf("v%0d_de_mis", i), 32'(de_misaligned), 32'(vecs[i].mis));
                check($sformatf("v%0d_de_pred", i), 32'(de_pred_taken), 32'h0);
            end
        end

        // Test 6: JAL at 0x10
        begin
            logic [31:0] got_pc[6];
            logic [31:0] got_insn[6];
            logic        got_pred[6];
            logic [31:0] exp_pc[6];
            int n;
            exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, PRED ? 32'h30 : 32'h14};
            jal_on = 1'b1;
            reset_dut();
            n = 0;
            for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
                @(posedge clk); #1;
                fe_ack = 1'b1; de_ready = 1'b1; redirect_valid = 1'b0;
                @(negedge clk);
                if (de_valid && de_ready) begin
                    got_pc[n] = de_pc; got_insn[n] = de_insn; got_pred[n] = de_pred_taken;
                    n++;
                end
            end
            check("t6_entries", 32'(n), 32'd6);
            for (int i = 0; i < n; i++) begin
                check($sformatf("t6_pc%0d", i), got_pc[i], exp_pc[i]);
                check($sformatf("t6_pred%0d", i), 32'(got_pred[i]),
                      32'((i == 4) && PRED));
            end
            if (n > 4) check("t6_jal_insn", got_insn[4], 32'h0200_006f);
        end

        // Randomized run against the stream model
        begin
            int          pops;
            bit          ok;
            logic [31:0] e_pc, e_insn, rpc;
            logic        e_mis, e_pred;
            rand_jal = 1'b1;
            reset_dut();
            m_pc = 32'h0; m_mode = 0; m_fault_pc = 32'h0;
            pops = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(posedge clk); #1;
                fe_ack   = ($urandom_range(0, 3) != 0);
                de_ready = ($urandom_range(0, 2) != 0);
                redirect_valid = (m_mode == 2) ? ($urandom_range(0, 3) == 0)
                                               : ($urandom_range(0, 39) == 0);
                rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
                redirect_pc = rpc;
                @(negedge clk);
                if (fe_req) check("rand_addr_aligned", 32'(fe_addr[1:0]), 32'h0);
                if (de_valid && de_ready) begin
                    pops++;
                    model_next(ok, e_pc, e_insn, e_mis, e_pred);
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL rand_unexpected_entry actual pc=%h required none", de_pc);
                    end else if (de_pc !== e_pc || de_insn !== e_insn ||
                                 de_misaligned !== e_mis || de_pred_taken !== e_pred) begin
                        errors++;
                        $display("FAIL rand_entry actual pc=%h insn=%h mis=%b pred=%b required pc=%h insn=%h mis=%b pred=%b",
                                 de_pc, de_insn, de_misaligned, de_pred_taken,
                                 e_pc, e_insn, e_mis, e_pred);
                    end
                end
                if (redirect_valid) begin
                    check("rand_req_in_redirect", 32'(fe_req), 32'h0);
                    model_redirect(redirect_pc);
                end
            end
            check("rand_progress", 32'(pops > 100), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
